// File: rtl/neogeo_pkg.sv
// Shared types for the 68000 bridge.
//   state_t  : bridge FSM states
//   M68K_AW  : width of the word address sent to the switch
package neogeo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        ERR
    } state_t;

    localparam int M68K_AW = 20;

endpackage

// File: rtl/m68k_bridge_sync2.sv
// sync2: two-flop synchroniser for one asynchronous input.
//   clk, rstn : clock, asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronised output (RST_VAL while in reset)
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/m68k_bridge.sv
// m68k_bridge: turns 68000 bus cycles from the cartridge slot into single
// m68kreq/m68kack transactions on the switch, and returns DTACK/BERR and
// read data to the CPU.
//   clk, rstn          : clock, asynchronous active-low reset
//   m68k_*  (in)       : raw asynchronous 68000 pins (AS, UDS, LDS, RW, A[23:1], D)
//   m68k_dout/doe      : read data and data-bus output enable to the CPU
//   m68k_dtack_n/berr_n: cycle termination to the CPU
//   m68kreq..m68kbe    : level request and its fields, held until m68kack
//   m68kack/m68krdata  : one-cycle completion pulse and read data from the switch
module m68k_bridge
    import neogeo_pkg::*;
#(
    parameter logic [2:0] BASE    = 3'd0,
    parameter int         TIMEOUT = 1023,
    parameter int         TW      = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               m68k_as_n,
    input  logic               m68k_uds_n,
    input  logic               m68k_lds_n,
    input  logic               m68k_rw,
    input  logic [22:0]        m68k_a,
    input  logic [15:0]        m68k_din,
    output logic [15:0]        m68k_dout,
    output logic               m68k_doe,
    output logic               m68k_dtack_n,
    output logic               m68k_berr_n,
    output logic               m68kreq,
    output logic [M68K_AW-1:0] m68kaddr,
    output logic [15:0]        m68kwdata,
    output logic               m68kwr,
    output logic [1:0]         m68kbe,
    input  logic               m68kack,
    input  logic [15:0]        m68krdata
);

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    logic as_s, uds_s, lds_s, rw_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_as  (.clk(clk), .rstn(rstn), .d(m68k_as_n),  .q(as_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_uds (.clk(clk), .rstn(rstn), .d(m68k_uds_n), .q(uds_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_lds (.clk(clk), .rstn(rstn), .d(m68k_lds_n), .q(lds_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_rw  (.clk(clk), .rstn(rstn), .d(m68k_rw),    .q(rw_s));

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [M68K_AW-1:0]  addr_q, addr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [1:0]          be_q, be_d;
    logic                dtack_n_q, dtack_n_d;
    logic                berr_n_q, berr_n_d;
    logic                doe_q, doe_d;
    logic [15:0]         dout_q, dout_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    // armed: a released AS has been seen in IDLE, so the next AS fall is a new cycle.
    logic                armed_q, armed_d;
    // settle: the synchronisers hold their reset value for two clocks after
    // reset; that value must not count as an observed AS release.
    logic [1:0]          settle_q, settle_d;
    // abort: AS was released while the request was outstanding.
    logic                abort_q, abort_d;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        be_d      = be_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;
        doe_d     = doe_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q;
        abort_d   = abort_q;
        settle_d  = {settle_q[0], 1'b1};

        case (state_q)
            IDLE: begin
                if (as_s && settle_q[1]) armed_d = 1'b1;
                // Writes raise DS after AS; wait for a strobe so D is valid.
                if (!as_s && armed_q && (!uds_s || !lds_s)) begin
                    armed_d = 1'b0;
                    if (m68k_a[22:20] == BASE) begin
                        addr_d  = m68k_a[M68K_AW-1:0];
                        wdata_d = m68k_din;
                        wr_d    = !rw_s;
                        be_d    = {!uds_s, !lds_s};
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        abort_d = 1'b0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
                if (as_s) abort_d = 1'b1;
                if (m68kack) begin
                    req_d = 1'b0;
                    if (abort_q || as_s) begin
                        state_d = IDLE;
                    end else begin
                        if (!wr_q) dout_d = m68krdata;
                        doe_d     = !wr_q;
                        dtack_n_d = 1'b0;
                        state_d   = ACK;
                    end
                end else if (cnt_d == TMO) begin
                    req_d = 1'b0;
                    // A CPU that already gave up on the cycle gets no BERR.
                    if (abort_q || as_s) begin
                        state_d = IDLE;
                    end else begin
                        berr_n_d = 1'b0;
                        state_d  = ERR;
                    end
                end
            end
            ACK: begin
                if (as_s) begin
                    dtack_n_d = 1'b1;
                    doe_d     = 1'b0;
                    state_d   = IDLE;
                end
            end
            ERR: begin
                if (as_s) begin
                    berr_n_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            be_q      <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            doe_q     <= 1'b0;
            dout_q    <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            settle_q  <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
            abort_q   <= abort_d;
        end
    end

    assign m68kreq      = req_q;
    assign m68kaddr     = addr_q;
    assign m68kwdata    = wdata_q;
    assign m68kwr       = wr_q;
    assign m68kbe       = be_q;
    assign m68k_dtack_n = dtack_n_q;
    assign m68k_berr_n  = berr_n_q;
    assign m68k_doe     = doe_q;
    assign m68k_dout    = dout_q;

endmodule

// File: tb/tb_m68k_bridge.sv
// Scoreboard bench for m68k_bridge: stimulus pushes expected switch requests
// and CPU terminations; a negedge monitor pops and compares them as the DUT
// raises m68kreq or drops DTACK/BERR.
module tb_m68k_bridge;

    localparam int EV_REQ   = 0;
    localparam int EV_DTACK = 1;
    localparam int EV_BERR  = 2;

    typedef struct {
        int          kind;
        logic [19:0] addr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] data;
        int          lat;
        int          len;
    } exp_t;

    logic        clk, rstn;
    logic        m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw;
    logic [22:0] m68k_a;
    logic [15:0] m68k_din, m68k_dout;
    logic        m68k_doe, m68k_dtack_n, m68k_berr_n;
    logic        m68kreq, m68kwr, m68kack;
    logic [19:0] m68kaddr;
    logic [15:0] m68kwdata, m68krdata;
    logic [1:0]  m68kbe;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   as_fall_cyc = 0;
    int   ack_cyc = 0;

    m68k_bridge #(.BASE(3'd0), .TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rstn(rstn),
        .m68k_as_n(m68k_as_n), .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n),
        .m68k_rw(m68k_rw), .m68k_a(m68k_a), .m68k_din(m68k_din),
        .m68k_dout(m68k_dout), .m68k_doe(m68k_doe),
        .m68k_dtack_n(m68k_dtack_n), .m68k_berr_n(m68k_berr_n),
        .m68kreq(m68kreq), .m68kaddr(m68kaddr), .m68kwdata(m68kwdata),
        .m68kwr(m68kwr), .m68kbe(m68kbe), .m68kack(m68kack), .m68krdata(m68krdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic prev_req = 1'b0, prev_dtack = 1'b1, prev_berr = 1'b1;
    int   req_len = 0, req_len_exp = 0;

    task automatic pop_ev(input int kind, input string name, output exp_t e, output bit ok);
        ok = 1'b0;
        if (sb.size() == 0 || sb[0].kind != kind) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got unexpected event, required kind %0d next (queue %0d)",
                     name, kind, sb.size());
        end else begin
            e  = sb.pop_front();
            ok = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (!rstn) begin
            prev_req = m68kreq; prev_dtack = m68k_dtack_n; prev_berr = m68k_berr_n;
            req_len = 0;
        end else begin
            if (m68kreq && !prev_req) begin
                pop_ev(EV_REQ, "req_rise", e, ok);
                if (ok) begin
                    chk("req_addr", 32'(m68kaddr), 32'(e.addr));
                    chk("req_wr",   32'(m68kwr),   32'(e.wr));
                    chk("req_be",   32'(m68kbe),   32'(e.be));
                    if (e.wr) chk("req_wdata", 32'(m68kwdata), 32'(e.data));
                    if (e.lat != 0) chk("req_latency", 32'(cyc - as_fall_cyc), 32'(e.lat));
                    req_len_exp = e.len;
                end
                req_len = 1;
            end else if (m68kreq) begin
                req_len++;
            end
            if (!m68kreq && prev_req && req_len_exp != 0) begin
                chk("req_length", 32'(req_len), 32'(req_len_exp));
                req_len_exp = 0;
            end
            if (!m68k_dtack_n && prev_dtack) begin
                pop_ev(EV_DTACK, "dtack_fall", e, ok);
                if (ok) begin
                    chk("dtack_doe", 32'(m68k_doe), e.wr ? 32'd0 : 32'd1);
                    if (!e.wr) chk("dtack_dout", 32'(m68k_dout), 32'(e.data));
                    if (e.lat != 0) chk("dtack_latency", 32'(cyc - ack_cyc), 32'(e.lat));
                end
            end
            if (!m68k_berr_n && prev_berr) begin
                pop_ev(EV_BERR, "berr_fall", e, ok);
                if (ok) chk("berr_with_req_low", 32'(m68kreq), 32'd0);
            end
            prev_req = m68kreq; prev_dtack = m68k_dtack_n; prev_berr = m68k_berr_n;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input int kind, input logic [19:0] addr, input logic wr,
                        input logic [1:0] be, input logic [15:0] data, input int lat, input int len);
        exp_t e;
        e.kind = kind; e.addr = addr; e.wr = wr; e.be = be; e.data = data; e.lat = lat; e.len = len;
        sb.push_back(e);
    endtask

    task automatic start_cycle(input logic [23:0] ba, input logic rw, input logic uds_n,
                               input logic lds_n, input logic [15:0] din);
        m68k_a = ba[23:1]; m68k_rw = rw; m68k_din = din;
        m68k_uds_n = uds_n; m68k_lds_n = lds_n; m68k_as_n = 1'b0;
        as_fall_cyc = cyc;
    endtask

    task automatic end_cycle();
        m68k_as_n = 1'b1; m68k_uds_n = 1'b1; m68k_lds_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 50; i++) begin
            if (m68kreq) return;
            step();
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: got no m68kreq within 50 clk, required a request", name);
    endtask

    task automatic pulse_ack(input logic [15:0] d);
        m68kack = 1'b1; m68krdata = d; ack_cyc = cyc;
        step();
        m68kack = 1'b0; m68krdata = 16'h0;
    endtask

    initial begin
        rstn = 1'b0; m68kack = 1'b0; m68krdata = 16'h0;
        m68k_a = 23'h0; m68k_rw = 1'b1; m68k_din = 16'h0;
        end_cycle();
        step(2);
        chk("rst_req",   32'(m68kreq),      32'd0);
        chk("rst_wr",    32'(m68kwr),       32'd0);
        chk("rst_addr",  32'(m68kaddr),     32'd0);
        chk("rst_wdata", 32'(m68kwdata),    32'd0);
        chk("rst_be",    32'(m68kbe),       32'd0);
        chk("rst_dtack", 32'(m68k_dtack_n), 32'd1);
        chk("rst_berr",  32'(m68k_berr_n),  32'd1);
        chk("rst_doe",   32'(m68k_doe),     32'd0);
        chk("rst_dout",  32'(m68k_dout),    32'd0);
        rstn = 1'b1;
        step(5);

        // Word read at 0x000100, ack after 5 clk with 0xBEEF.
        push(EV_REQ, 20'h00080, 1'b0, 2'b11, 16'h0, 3, 0);
        push(EV_DTACK, 20'h0, 1'b0, 2'b00, 16'hBEEF, 1, 0);
        start_cycle(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_req("read_req");
        step(4);
        pulse_ack(16'hBEEF);
        step(3);
        chk("read_dtack_held", 32'(m68k_dtack_n), 32'd0);
        chk("read_doe_held",   32'(m68k_doe),     32'd1);
        end_cycle();
        step(4);
        chk("read_dtack_release", 32'(m68k_dtack_n), 32'd1);
        chk("read_doe_release",   32'(m68k_doe),     32'd0);

        // Byte write, LDS only, DS arrives after AS.
        start_cycle(24'h000202, 1'b0, 1'b1, 1'b1, 16'h0055);
        step(5);
        chk("write_waits_for_ds", 32'(m68kreq), 32'd0);
        push(EV_REQ, 20'h00101, 1'b1, 2'b01, 16'h0055, 0, 0);
        push(EV_DTACK, 20'h0, 1'b1, 2'b00, 16'h0, 1, 0);
        m68k_lds_n = 1'b0;
        wait_req("write_req");
        step(2);
        pulse_ack(16'h0);
        step(2);
        chk("write_dtack_held", 32'(m68k_dtack_n), 32'd0);
        end_cycle();
        step(4);
        chk("write_dtack_release", 32'(m68k_dtack_n), 32'd1);

        // Foreign window A[23:21]=5: nothing happens.
        start_cycle(24'hA00000, 1'b1, 1'b0, 1'b0, 16'h0);
        for (int k = 0; k < 2; k++) begin
            step(6);
            chk("foreign_no_req",   32'(m68kreq),      32'd0);
            chk("foreign_no_dtack", 32'(m68k_dtack_n), 32'd1);
            chk("foreign_no_berr",  32'(m68k_berr_n),  32'd1);
        end
        end_cycle();
        step(4);

        // No ack: timeout after 16 clk, BERR until AS rises, late ack ignored.
        push(EV_REQ, 20'h00180, 1'b0, 2'b11, 16'h0, 3, 16);
        push(EV_BERR, 20'h0, 1'b0, 2'b00, 16'h0, 0, 0);
        start_cycle(24'h000300, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_req("timeout_req");
        step(20);
        chk("timeout_berr",   32'(m68k_berr_n), 32'd0);
        chk("timeout_req_lo", 32'(m68kreq),     32'd0);
        pulse_ack(16'h1234);
        step(3);
        chk("late_ack_berr",  32'(m68k_berr_n),  32'd0);
        chk("late_ack_dtack", 32'(m68k_dtack_n), 32'd1);
        end_cycle();
        step(4);
        chk("timeout_berr_release", 32'(m68k_berr_n), 32'd1);

        // Abort: AS rises at clk 2 of REQ, ack at clk 6; no DTACK.
        push(EV_REQ, 20'h00200, 1'b0, 2'b11, 16'h0, 3, 0);
        start_cycle(24'h000400, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_req("abort_req");
        step(2);
        end_cycle();
        step(4);
        pulse_ack(16'hDEAD);
        chk("abort_req_lo", 32'(m68kreq), 32'd0);
        step(6);
        chk("abort_no_dtack", 32'(m68k_dtack_n), 32'd1);

        // Next cycle served normally: word write 0x1234 at 0x000010.
        push(EV_REQ, 20'h00008, 1'b1, 2'b11, 16'h1234, 3, 0);
        push(EV_DTACK, 20'h0, 1'b1, 2'b00, 16'h0, 1, 0);
        start_cycle(24'h000010, 1'b0, 1'b0, 1'b0, 16'h1234);
        wait_req("post_abort_req");
        step(1);
        pulse_ack(16'h0);
        step(2);
        end_cycle();
        step(4);
        chk("post_abort_release", 32'(m68k_dtack_n), 32'd1);

        // Reset while in ACK, then wait for a fresh AS fall.
        push(EV_REQ, 20'h00010, 1'b0, 2'b11, 16'h0, 3, 0);
        push(EV_DTACK, 20'h0, 1'b0, 2'b00, 16'h0F0F, 1, 0);
        start_cycle(24'h000020, 1'b1, 1'b0, 1'b0, 16'h0);
        wait_req("rst_ack_req");
        step(1);
        pulse_ack(16'h0F0F);
        step(2);
        chk("pre_rst_dtack", 32'(m68k_dtack_n), 32'd0);
        rstn = 1'b0;
        #1;
        chk("async_rst_dtack", 32'(m68k_dtack_n), 32'd1);
        chk("async_rst_doe",   32'(m68k_doe),     32'd0);
        chk("async_rst_req",   32'(m68kreq),      32'd0);
        step(2);
        rstn = 1'b1;
        step(10);
        chk("post_rst_no_req", 32'(m68kreq), 32'd0);
        end_cycle();
        step(4);
        push(EV_REQ, 20'h00010, 1'b0, 2'b10, 16'h0, 3, 0);
        push(EV_DTACK, 20'h0, 1'b0, 2'b00, 16'hA5A5, 1, 0);
        start_cycle(24'h000020, 1'b1, 1'b0, 1'b1, 16'h0);
        wait_req("fresh_req");
        step(3);
        pulse_ack(16'hA5A5);
        step(2);
        end_cycle();
        step(4);
        chk("fresh_release", 32'(m68k_dtack_n), 32'd1);

        step(2);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
